// File: rtl/ifetch_sequencer_pkg.sv
// rtl/ifetch_sequencer_pkg.sv - shared types, constants and range check for the fetch sequencer
// Contents: fetch_state_e (FSM states), INST_BYTES, IMEM_LAST_ADDR_DEFAULT,
//           fetch_out_of_range() helper.
package ifetch_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   localparam int          INST_BYTES             = 4;
   localparam logic [63:0] IMEM_LAST_ADDR_DEFAULT = 64'd263;

   // The last byte of the instruction is checked in 65 bits so that a PC
   // near 2^64 wraps into the carry bit and is reported as out of range.
   function automatic logic fetch_out_of_range(input logic [63:0] pc,
                                               input logic [63:0] last_addr);
      logic [64:0] end_addr;
      end_addr = {1'b0, pc} + 65'(INST_BYTES - 1);
      return end_addr > {1'b0, last_addr};
   endfunction

endpackage

// File: rtl/ifetch_sequencer_if.sv
// rtl/ifetch_sequencer_if.sv - PC, instruction-memory and IF/ID signals of the fetch sequencer
// Modports: master = sequencer side (drives pc_write/pc_next, imem_req/imem_addr,
//           inst_valid/inst_out/inst_pc, fetch_fault); slave = surrounding pipeline.
interface ifetch_sequencer_if;

   logic [63:0] pc_in;
   logic        pc_write;
   logic [63:0] pc_next;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [7:0]  imem_rdata;
   logic        flush;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [63:0] inst_pc;
   logic        fetch_fault;

   modport master (
      input  pc_in, imem_ack, imem_rdata, flush, inst_ready,
      output pc_write, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault
   );

   modport slave (
      output pc_in, imem_ack, imem_rdata, flush, inst_ready,
      input  pc_write, pc_next, imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault
   );

endinterface

// File: rtl/ifetch_sequencer_inst_byte_assembler.sv
// rtl/ifetch_sequencer_inst_byte_assembler.sv - little-endian byte-lane capture of one instruction
// Ports: clk, reset (sync, active-high), clear_i (sync clear), wr_en_i (ack-qualified
//        write), index_i (byte lane, 0 = bits 7:0), data_i (byte), word_o (assembled word).
module inst_byte_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        wr_en_i,
   input  logic [1:0]  index_i,
   input  logic [7:0]  data_i,
   output logic [31:0] word_o
);

   logic [31:0] word_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         word_q <= '0;
      end else if (wr_en_i) begin
         case (index_i)
            2'd0:    word_q[7:0]   <= data_i;
            2'd1:    word_q[15:8]  <= data_i;
            2'd2:    word_q[23:16] <= data_i;
            default: word_q[31:24] <= data_i;
         endcase
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/ifetch_sequencer.sv
// rtl/ifetch_sequencer.sv - byte-serial instruction fetch FSM between PC counter, IMEM and IF/ID
// Ports: clk, reset (sync, active-high), bus (ifetch_sequencer_if.master):
//        pc_in -> pc_write/pc_next, imem_req/imem_addr <- imem_ack/imem_rdata,
//        flush, inst_valid/inst_out/inst_pc <- inst_ready, fetch_fault.
module ifetch_sequencer
   import ifetch_sequencer_pkg::*;
#(
   parameter logic [63:0] IMEM_LAST_ADDR = IMEM_LAST_ADDR_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   ifetch_sequencer_if.master  bus
);

   fetch_state_e state_q, state_d;
   logic [63:0]  base_q, base_d;
   logic [1:0]   index_q, index_d;

   logic         asm_clear;
   logic         asm_wr;
   logic [31:0]  asm_word;

   logic         pc_write;
   logic [63:0]  pc_next;
   logic         imem_req;
   logic [63:0]  imem_addr;
   logic         inst_valid;
   logic         fetch_fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         index_q <= index_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      index_d     = index_q;
      asm_clear   = 1'b0;
      asm_wr      = 1'b0;
      pc_write    = 1'b0;
      pc_next     = '0;
      imem_req    = 1'b0;
      imem_addr   = '0;
      inst_valid  = 1'b0;
      fetch_fault = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Lanes are wiped here so a flushed partial word never leaks into the next fetch.
            asm_clear = 1'b1;
            base_d    = bus.pc_in;
            index_d   = 2'd0;
            if (fetch_out_of_range(bus.pc_in, IMEM_LAST_ADDR)) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            imem_req  = 1'b1;
            imem_addr = base_q + {62'd0, index_q};
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else if (bus.imem_ack) begin
               asm_wr = 1'b1;
               if (index_q == 2'd3) begin
                  state_d = ST_HOLD;
               end else begin
                  index_d = index_q + 2'd1;
               end
            end
         end

         ST_HOLD: begin
            // flush wins over the handshake: the word is dropped and the PC does not advance.
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else begin
               inst_valid = 1'b1;
               if (bus.inst_ready) begin
                  pc_write = 1'b1;
                  pc_next  = base_q + 64'(INST_BYTES);
                  state_d  = ST_IDLE;
               end
            end
         end

         ST_FAULT: begin
            fetch_fault = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   inst_byte_assembler u_assembler (
      .clk     (clk),
      .reset   (reset),
      .clear_i (asm_clear),
      .wr_en_i (asm_wr),
      .index_i (index_q),
      .data_i  (bus.imem_rdata),
      .word_o  (asm_word)
   );

   assign bus.pc_write    = pc_write;
   assign bus.pc_next     = pc_next;
   assign bus.imem_req    = imem_req;
   assign bus.imem_addr   = imem_addr;
   assign bus.inst_valid  = inst_valid;
   assign bus.inst_out    = asm_word;
   assign bus.inst_pc     = base_q;
   assign bus.fetch_fault = fetch_fault;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb/tb_ifetch_sequencer.sv - directed vector bench for ifetch_sequencer
module tb_ifetch_sequencer;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   ifetch_sequencer_if bus ();

   ifetch_sequencer #(.IMEM_LAST_ADDR(64'd263)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        ack;
      logic        ready;
      logic [63:0] pc;
      logic [7:0]  rdata;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [31:0] e_out;
      logic [63:0] e_ipc;
      logic        e_pw;
      logic [63:0] e_pn;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic fl, input logic ack, input logic rdy,
                              input logic [63:0] pc, input logic [7:0] rd,
                              input logic req, input logic [63:0] addr, input logic val,
                              input logic [31:0] out, input logic [63:0] ipc,
                              input logic pw, input logic [63:0] pn);
      vec_t r;
      r.flush = fl;  r.ack = ack;  r.ready = rdy;  r.pc = pc;  r.rdata = rd;
      r.e_req = req; r.e_addr = addr; r.e_valid = val; r.e_out = out;
      r.e_ipc = ipc; r.e_pw = pw; r.e_pn = pn;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [63:0] addr,
                          input logic val, input logic [31:0] out, input logic [63:0] ipc,
                          input logic pw, input logic [63:0] pn, input logic fault);
      check($sformatf("%s.imem_req", tag),    64'(bus.imem_req),    64'(req));
      check($sformatf("%s.imem_addr", tag),   bus.imem_addr,        addr);
      check($sformatf("%s.inst_valid", tag),  64'(bus.inst_valid),  64'(val));
      check($sformatf("%s.inst_out", tag),    64'(bus.inst_out),    64'(out));
      check($sformatf("%s.inst_pc", tag),     bus.inst_pc,          ipc);
      check($sformatf("%s.pc_write", tag),    64'(bus.pc_write),    64'(pw));
      check($sformatf("%s.pc_next", tag),     bus.pc_next,          pn);
      check($sformatf("%s.fetch_fault", tag), 64'(bus.fetch_fault), 64'(fault));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, input logic ack, input logic rdy,
                        input logic [63:0] pc, input logic [7:0] rd);
      bus.flush = fl; bus.imem_ack = ack; bus.inst_ready = rdy;
      bus.pc_in = pc; bus.imem_rdata = rd;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] bytes4 [4];
      n_tests = 0;
      n_fail  = 0;

      // Two instructions back to back: full-speed fetch, then a 3-cycle decode stall.
      vecs.push_back(v(0,1,1, 64'd0, 8'h13, 0,64'd0, 0,32'h0,        64'd0, 0,64'd0));
      vecs.push_back(v(0,1,1, 64'd0, 8'h13, 1,64'd0, 0,32'h0,        64'd0, 0,64'd0));
      vecs.push_back(v(0,1,1, 64'd0, 8'h00, 1,64'd1, 0,32'h13,       64'd0, 0,64'd0));
      vecs.push_back(v(0,1,1, 64'd0, 8'h50, 1,64'd2, 0,32'h13,       64'd0, 0,64'd0));
      vecs.push_back(v(0,1,1, 64'd0, 8'h00, 1,64'd3, 0,32'h00500013, 64'd0, 0,64'd0));
      vecs.push_back(v(0,1,1, 64'd0, 8'h00, 0,64'd0, 1,32'h00500013, 64'd0, 1,64'd4));
      vecs.push_back(v(0,1,0, 64'd4, 8'h93, 0,64'd0, 0,32'h00500013, 64'd0, 0,64'd0));
      vecs.push_back(v(0,1,0, 64'd4, 8'h93, 1,64'd4, 0,32'h0,        64'd4, 0,64'd0));
      vecs.push_back(v(0,1,0, 64'd4, 8'h00, 1,64'd5, 0,32'h93,       64'd4, 0,64'd0));
      vecs.push_back(v(0,1,0, 64'd4, 8'h10, 1,64'd6, 0,32'h93,       64'd4, 0,64'd0));
      vecs.push_back(v(0,1,0, 64'd4, 8'h00, 1,64'd7, 0,32'h00100093, 64'd4, 0,64'd0));
      vecs.push_back(v(0,0,0, 64'd4, 8'hee, 0,64'd0, 1,32'h00100093, 64'd4, 0,64'd0));
      vecs.push_back(v(0,0,0, 64'd4, 8'hee, 0,64'd0, 1,32'h00100093, 64'd4, 0,64'd0));
      vecs.push_back(v(0,0,0, 64'd4, 8'hee, 0,64'd0, 1,32'h00100093, 64'd4, 0,64'd0));
      vecs.push_back(v(0,0,1, 64'd4, 8'hee, 0,64'd0, 1,32'h00100093, 64'd4, 1,64'd8));
      vecs.push_back(v(0,0,0, 64'd8, 8'h00, 0,64'd0, 0,32'h00100093, 64'd4, 0,64'd0));

      do_reset();
      foreach (vecs[i]) begin
         drive(vecs[i].flush, vecs[i].ack, vecs[i].ready, vecs[i].pc, vecs[i].rdata);
         chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_out, vecs[i].e_ipc, vecs[i].e_pw, vecs[i].e_pn, 1'b0);
         tick();
      end

      // Now in FETCH at base 8: ack only every other cycle, address held until acked.
      bytes4[0] = 8'hA1; bytes4[1] = 8'hB2; bytes4[2] = 8'hC3; bytes4[3] = 8'hD4;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, k[0], 1'b0, 64'd8, k[0] ? bytes4[k/2] : 8'h5A);
         check($sformatf("slow%0d.imem_req", k), 64'(bus.imem_req), 64'd1);
         check($sformatf("slow%0d.imem_addr", k), bus.imem_addr, 64'd8 + 64'(k/2));
         check($sformatf("slow%0d.pc_write", k), 64'(bus.pc_write), 64'd0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b1, 64'd8, 8'h00);
      chk_all("slow_hold", 1'b0, 64'd0, 1'b1, 32'hD4C3B2A1, 64'd8, 1'b1, 64'd12, 1'b0);
      tick();

      // Flush after two bytes, then restart from a new PC.
      drive(1'b0, 1'b1, 1'b1, 64'd12, 8'h11);           // IDLE
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd12, 8'h11);
      check("fl.addr12", bus.imem_addr, 64'd12);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd12, 8'h22);
      check("fl.addr13", bus.imem_addr, 64'd13);
      tick();
      drive(1'b1, 1'b1, 1'b1, 64'd12, 8'h33);           // flush in FETCH, byte 2
      check("fl.fetch.valid", 64'(bus.inst_valid), 64'd0);
      check("fl.fetch.pw", 64'(bus.pc_write), 64'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h01);          // IDLE
      chk_all("fl.idle", 1'b0, 64'd0, 1'b0, 32'h2211, 64'd12, 1'b0, 64'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h01);
      chk_all("fl.restart", 1'b1, 64'd100, 1'b0, 32'h0, 64'd100, 1'b0, 64'd0, 1'b0);
      tick();
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 1'b1, 1'b1, 64'd100, 8'(k + 1));
         tick();
      end
      // Flush during the handshake cycle: not accepted, no PC advance.
      drive(1'b1, 1'b0, 1'b1, 64'd100, 8'h00);
      check("fl.hs.valid", 64'(bus.inst_valid), 64'd0);
      check("fl.hs.pw", 64'(bus.pc_write), 64'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h77);          // IDLE
      check("fl.hs.idle.req", 64'(bus.imem_req), 64'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h77);          // FETCH byte 0
      check("fl.refetch.addr", bus.imem_addr, 64'd100);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h88);          // FETCH byte 1
      check("rst.mid.addr", bus.imem_addr, 64'd101);
      // Reset beats ack and flush mid-FETCH.
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 64'd100, 8'h99);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h44);
      chk_all("rst.mid", 1'b0, 64'd0, 1'b0, 32'h0, 64'd0, 1'b0, 64'd0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 64'd100, 8'h44);
      chk_all("rst.restart", 1'b1, 64'd100, 1'b0, 32'h0, 64'd100, 1'b0, 64'd0, 1'b0);
      tick();

      // Flush in IDLE is ignored.
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 64'd20, 8'h00);
      tick();
      drive(1'b0, 1'b0, 1'b0, 64'd20, 8'h00);
      check("idle_flush.req", 64'(bus.imem_req), 64'd1);
      check("idle_flush.addr", bus.imem_addr, 64'd20);

      // Highest in-range PC: 260 + 3 = 263.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'd260, 8'h00);
      tick();
      chk_all("edge260", 1'b1, 64'd260, 1'b0, 32'h0, 64'd260, 1'b0, 64'd0, 1'b0);

      // 261 + 3 > 263 faults; flush cannot leave FAULT.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'd261, 8'h00);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 1'b1, 64'd261, 8'hFF);
         check($sformatf("fault%0d.fault", k), 64'(bus.fetch_fault), 64'd1);
         check($sformatf("fault%0d.req", k), 64'(bus.imem_req), 64'd0);
         check($sformatf("fault%0d.valid", k), 64'(bus.inst_valid), 64'd0);
         check($sformatf("fault%0d.pw", k), 64'(bus.pc_write), 64'd0);
         tick();
      end
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'd0, 8'h00);
      check("fault.cleared", 64'(bus.fetch_fault), 64'd0);

      // PC whose last byte wraps past 2^64 faults.
      drive(1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00);
      tick();
      check("wrap.fault", 64'(bus.fetch_fault), 64'd1);
      check("wrap.req", 64'(bus.imem_req), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_sequencer.md
IFETCH_SEQUENCER -- requirements
Module: ifetch_sequencer

Interface
REQ-001 Parameter IMEM_LAST_ADDR, default 263, SHALL be the highest valid byte address of instruction memory.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 pc_in  input  64  SHALL be the current PC from the PC counter.
REQ-005 pc_write  output  1  SHALL be the one-cycle advance strobe to the PC counter.
REQ-006 pc_next  output  64  SHALL be the next sequential PC for the PC counter.
REQ-007 imem_req  output  1  SHALL request one byte read.
REQ-008 imem_addr  output  64  SHALL be the requested byte address.
REQ-009 imem_ack  input  1  SHALL mark imem_rdata valid in this cycle.
REQ-010 imem_rdata  input  8  SHALL be the read byte.
REQ-011 flush  input  1  SHALL abort the fetch in progress (taken branch or jump).
REQ-012 inst_valid  output  1  SHALL flag inst_out/inst_pc valid toward IF/ID.
REQ-013 inst_ready  input  1  SHALL be IF/ID acceptance; low means decode stall.
REQ-014 inst_out  output  32  SHALL be the assembled instruction.
REQ-015 inst_pc  output  64  SHALL be the address of inst_out.
REQ-016 fetch_fault  output  1  SHALL flag a fetch outside instruction memory.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD, FAULT.
REQ-018 IDLE SHALL latch base=pc_in and byte index 0, then go to FETCH; if pc_in+3 > IMEM_LAST_ADDR (computed in 65 bits, so 64-bit wrap also faults) it SHALL go to FAULT instead.
REQ-019 FETCH SHALL hold imem_req=1 and imem_addr=base+index, and SHALL wait any number of cycles for imem_ack.
REQ-020 On imem_ack, imem_rdata SHALL be stored in byte lane [index] (little-endian; lane 0 = inst_out[7:0]); index 3 then goes to HOLD, otherwise index increments.
REQ-021 imem_rdata SHALL be ignored in any cycle without imem_ack.
REQ-022 HOLD SHALL assert inst_valid with inst_out and inst_pc=base stable until inst_valid&&inst_ready.
REQ-023 On inst_valid&&inst_ready, pc_write SHALL pulse high for exactly that cycle with pc_next=base+4 (mod 2^64), and the FSM SHALL return to IDLE.
REQ-024 pc_write SHALL be low in every other cycle, so the PC counter holds.
REQ-025 Minimum latency with imem_ack always high SHALL be: IDLE 1 cycle, FETCH 4 cycles, inst_valid in cycle 6.
REQ-026 flush in FETCH or HOLD SHALL discard the partial or held instruction, suppress pc_write, gate inst_valid low in that cycle, and go to IDLE.
REQ-027 flush in the handshake cycle SHALL win: the instruction is not accepted and pc_write stays 0.
REQ-028 flush in IDLE SHALL have no effect.
REQ-029 FAULT SHALL hold fetch_fault=1, imem_req=0, inst_valid=0 and pc_write=0 until reset; flush SHALL NOT leave FAULT.

Reset
REQ-030 Reset SHALL have priority over flush, imem_ack and inst_ready.
REQ-031 Reset in any state, including mid-FETCH, SHALL drop the partial instruction, and the next state SHALL be IDLE.
REQ-032 Reset values SHALL be: pc_write=0, pc_next=0, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, fetch_fault=0, base=0, index=0.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, INST_BYTES=4 and the IMEM_LAST_ADDR default.
REQ-034 Byte-lane capture SHALL be one sub-module, inst_byte_assembler: 2-bit index, ack-qualified write, clear input.

Verification
REQ-035 Reset, then pc_in=0 and imem_ack=1 with bytes 13,00,50,00 -> inst_valid in cycle 6, inst_out=0x00500013, inst_pc=0, one pc_write with pc_next=4.
REQ-036 inst_ready low for 3 cycles in HOLD -> outputs stable, pc_write=0 throughout, then a single pulse when inst_ready rises.
REQ-037 pc_in=8, imem_ack high only every other cycle -> imem_addr steps 8,9,10,11, each held until acked; pc_next=12.
REQ-038 flush after 2 bytes, pc_in then 100 -> no pc_write and no inst_valid; the new fetch starts at imem_addr=100.
REQ-039 pc_in=261 (261+3>263) -> FAULT, fetch_fault=1, imem_req=0; flush does not clear it; reset clears it.
REQ-040 Reset asserted mid-FETCH together with imem_ack and flush -> all outputs at reset values next cycle; fetch restarts at byte 0.
